// File: rtl/filter_pkg.sv
// filter_pkg: shared state encoding, default geometry and window slot indexing
// for the filter scheduler and its window register.
package filter_pkg;
    typedef enum logic [2:0] {IDLE, FILL, SHIFT, REFRESH, WAIT, WRITE, DONE} state_t;
    localparam int KS_DEF    = 9;
    localparam int PIX_W_DEF = 10;
    function automatic int slot_idx(int r, int c, int ks);
        return r * ks + c;
    endfunction
endpackage

// File: rtl/window_reg.sv
// window_reg: KS x KS pixel window with single-slot load and shift-left-by-one-column,
// flattened row-major onto the datapath bus.
module window_reg
    import filter_pkg::*;
#(
    parameter int KS    = KS_DEF,
    parameter int PIX_W = PIX_W_DEF,
    localparam int IW   = $clog2(KS * KS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_i,
    input  logic                    ld_en_i,
    input  logic [IW-1:0]           ld_idx_i,
    input  logic [PIX_W-1:0]        ld_data_i,
    output logic [KS*KS*PIX_W-1:0]  data_bus_o
);
    logic [PIX_W-1:0] win_q [KS*KS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KS * KS; i++) win_q[i] <= '0;
        end else if (shift_i) begin
            for (int r = 0; r < KS; r++)
                for (int c = 0; c < KS - 1; c++)
                    win_q[slot_idx(r, c, KS)] <= win_q[slot_idx(r, c + 1, KS)];
        end else if (ld_en_i) begin
            win_q[ld_idx_i] <= ld_data_i;
        end
    end

    for (genvar i = 0; i < KS * KS; i++) begin : g_bus
        assign data_bus_o[i*PIX_W +: PIX_W] = win_q[i];
    end
endmodule

// File: rtl/filter_scheduler.sv
// filter_scheduler: walks a KS x KS window over the source image, feeds each window
// to the filter datapath and writes every result to the destination RAM.
module filter_scheduler
    import filter_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int KS     = KS_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int OP_LAT = 2,
    parameter int ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    src_rd,
    output logic [ADDR_W-1:0]       src_addr,
    input  logic [PIX_W-1:0]        src_data,
    output logic [KS*KS*PIX_W-1:0]  data_bus,
    output logic                    refresh,
    input  logic [PIX_W-1:0]        op_out,
    output logic                    dst_we,
    output logic [ADDR_W-1:0]       dst_addr,
    output logic [PIX_W-1:0]        dst_data
);
    localparam int OW = IMG_W - KS + 1;
    localparam int OH = IMG_H - KS + 1;
    localparam int NW = KS * KS;
    localparam int CW = $clog2(NW + OP_LAT + 2);
    localparam int RW = $clog2(KS + 1);
    localparam int IW = $clog2(NW);

    if (IMG_W * IMG_H > 2 ** ADDR_W || IMG_W < KS || IMG_H < KS || OP_LAT < 1) begin : g_param_chk
        $error("filter_scheduler: image does not fit the address space or geometry is invalid");
    end

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [RW-1:0]     rd_r_q, rd_c_q, rd_r_d, rd_c_d;
    logic [ADDR_W-1:0] ox_q, oy_q, src_addr_q, dst_addr_q;
    logic              busy_q, done_q, src_rd_q, refresh_q, dst_we_q;
    logic              ld_en, shift_en;
    logic [IW-1:0]     ld_idx;

    function automatic logic [ADDR_W-1:0] src_at(logic [ADDR_W-1:0] x, logic [ADDR_W-1:0] y);
        return y * ADDR_W'(IMG_W) + x;
    endfunction

    // Captures trail their reads by one cycle, so slot cnt-1 is written at cnt.
    always_comb begin
        rd_r_d   = rd_c_q == RW'(KS - 1) ? rd_r_q + 1'b1 : rd_r_q;
        rd_c_d   = rd_c_q == RW'(KS - 1) ? '0 : rd_c_q + 1'b1;
        ld_en    = (state_q == FILL || state_q == SHIFT) && cnt_q != '0;
        shift_en = state_q == SHIFT && cnt_q == '0;
        ld_idx   = state_q == FILL ? IW'(cnt_q - 1'b1)
                                   : IW'(slot_idx(int'(cnt_q) - 1, KS - 1, KS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_r_q     <= '0;
            rd_c_q     <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_rd_q   <= 1'b0;
            src_addr_q <= '0;
            refresh_q  <= 1'b0;
            dst_we_q   <= 1'b0;
            dst_addr_q <= '0;
        end else begin
            src_rd_q  <= 1'b0;
            refresh_q <= 1'b0;
            dst_we_q  <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= cnt_q + 1'b1;
            unique case (state_q)
                IDLE: if (start) begin
                    state_q    <= FILL;
                    cnt_q      <= '0;
                    rd_r_q     <= '0;
                    rd_c_q     <= '0;
                    ox_q       <= '0;
                    oy_q       <= '0;
                    busy_q     <= 1'b1;
                    src_rd_q   <= 1'b1;
                    src_addr_q <= '0;
                end
                FILL: begin
                    if (cnt_q < CW'(NW - 1)) begin
                        src_rd_q   <= 1'b1;
                        rd_r_q     <= rd_r_d;
                        rd_c_q     <= rd_c_d;
                        src_addr_q <= src_at(ox_q + ADDR_W'(rd_c_d), oy_q + ADDR_W'(rd_r_d));
                    end
                    if (cnt_q == CW'(NW)) begin
                        state_q   <= REFRESH;
                        refresh_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q < CW'(KS - 1)) begin
                        src_rd_q   <= 1'b1;
                        src_addr_q <= src_at(ox_q + ADDR_W'(KS - 1), oy_q + ADDR_W'(cnt_q) + 1'b1);
                    end
                    if (cnt_q == CW'(KS)) begin
                        state_q   <= REFRESH;
                        refresh_q <= 1'b1;
                    end
                end
                REFRESH: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: if (cnt_q == CW'(OP_LAT - 1)) begin
                    state_q    <= WRITE;
                    dst_we_q   <= 1'b1;
                    dst_addr_q <= oy_q * ADDR_W'(OW) + ox_q;
                end
                WRITE: begin
                    cnt_q <= '0;
                    if (ox_q < ADDR_W'(OW - 1)) begin
                        state_q    <= SHIFT;
                        ox_q       <= ox_q + 1'b1;
                        src_rd_q   <= 1'b1;
                        src_addr_q <= src_at(ox_q + ADDR_W'(KS), oy_q);
                    end else if (oy_q < ADDR_W'(OH - 1)) begin
                        state_q    <= FILL;
                        ox_q       <= '0;
                        oy_q       <= oy_q + 1'b1;
                        rd_r_q     <= '0;
                        rd_c_q     <= '0;
                        src_rd_q   <= 1'b1;
                        src_addr_q <= src_at('0, oy_q + 1'b1);
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    window_reg #(.KS(KS), .PIX_W(PIX_W)) u_win (
        .clk        (clk),
        .rst_n      (rst),
        .shift_i    (shift_en),
        .ld_en_i    (ld_en),
        .ld_idx_i   (ld_idx),
        .ld_data_i  (src_data),
        .data_bus_o (data_bus)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign src_rd   = src_rd_q;
    assign src_addr = src_addr_q;
    assign refresh  = refresh_q;
    assign dst_we   = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_data = dst_we_q ? op_out : '0;
endmodule

// File: tb/tb_filter_scheduler.sv
// tb_filter_scheduler: two scheduler instances (10x10 with 4-cycle datapath, 9x9 with
// 2-cycle datapath) against behavioural source RAM and filter models.
module tb_filter_scheduler;
    localparam int KS = 9, PW = 10, AW = 12, NB = KS * KS * PW;
    localparam int AIW = 10, AIH = 10, ALAT = 4;
    localparam int BIW = 9, BIH = 9, BLAT = 2;
    localparam logic [PW-1:0] JUNK_OP = 10'h3FF, JUNK_SRC = 10'h2AA;

    typedef struct { logic [AW-1:0] addr; logic [PW-1:0] data; int gap; } wr_t;
    typedef struct { logic [AW-1:0] addr; logic [PW-1:0] data; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_a = 1'b0, start_a = 1'b0, busy_a, done_a, rd_a, ref_a, we_a;
    logic [AW-1:0] addr_a, waddr_a;
    logic [PW-1:0] sdat_a = '0, op_a = JUNK_OP, wdat_a, v_a = '0;
    logic [NB-1:0] bus_a;
    logic          rst_b = 1'b0, start_b = 1'b0, busy_b, done_b, rd_b, ref_b, we_b;
    logic [AW-1:0] addr_b, waddr_b;
    logic [PW-1:0] sdat_b = '0, op_b = JUNK_OP, wdat_b, v_b = '0;
    logic [NB-1:0] bus_b;

    filter_scheduler #(.IMG_W(AIW), .IMG_H(AIH), .KS(KS), .PIX_W(PW), .OP_LAT(ALAT), .ADDR_W(AW)) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .src_rd(rd_a), .src_addr(addr_a), .src_data(sdat_a), .data_bus(bus_a),
        .refresh(ref_a), .op_out(op_a), .dst_we(we_a), .dst_addr(waddr_a), .dst_data(wdat_a));

    filter_scheduler #(.IMG_W(BIW), .IMG_H(BIH), .KS(KS), .PIX_W(PW), .OP_LAT(BLAT), .ADDR_W(AW)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .src_rd(rd_b), .src_addr(addr_b), .src_data(sdat_b), .data_bus(bus_b),
        .refresh(ref_b), .op_out(op_b), .dst_we(we_b), .dst_addr(waddr_b), .dst_data(wdat_b));

    // Pixel (x,y) holds y*IMG_W+x, which equals its own address.
    always @(posedge clk) sdat_a <= rd_a ? addr_a[PW-1:0] : JUNK_SRC;
    always @(posedge clk) sdat_b <= rd_b ? addr_b[PW-1:0] : JUNK_SRC;

    // Filter model: top-left pixel of the window, valid exactly OP_LAT cycles after refresh.
    int k_a = 0, k_b = 0;
    always @(posedge clk) begin
        if (ref_a) begin
            k_a <= 1; v_a <= bus_a[PW-1:0]; op_a <= JUNK_OP;
        end else if (k_a != 0) begin
            if (k_a + 1 == ALAT) begin op_a <= v_a; k_a <= 0; end
            else k_a <= k_a + 1;
        end
    end
    always @(posedge clk) begin
        if (ref_b) begin
            k_b <= 1; v_b <= bus_b[PW-1:0]; op_b <= JUNK_OP;
        end else if (k_b != 0) begin
            if (k_b + 1 == BLAT) begin op_b <= v_b; k_b <= 0; end
            else k_b <= k_b + 1;
        end
    end

    logic [AW-1:0] rd_q_a[$];
    logic [NB-1:0] bus_q_a[$];
    wr_t           wr_q_a[$];
    int            n_done_a = 0, last_ref_a = 0;
    always @(negedge clk) begin
        if (rd_a) rd_q_a.push_back(addr_a);
        if (ref_a) begin bus_q_a.push_back(bus_a); last_ref_a = cyc; end
        if (we_a) wr_q_a.push_back('{waddr_a, wdat_a, cyc - last_ref_a});
        if (done_a) n_done_a++;
    end

    int            n_rd_b = 0, n_ref_b = 0, n_we_b = 0, n_done_b = 0;
    logic [NB-1:0] bus_b_s = '0;
    logic [AW-1:0] wa_b_s = '0;
    logic [PW-1:0] wd_b_s = '0;
    always @(negedge clk) begin
        if (rd_b) n_rd_b++;
        if (ref_b) begin n_ref_b++; bus_b_s = bus_b; end
        if (we_b) begin n_we_b++; wa_b_s = waddr_b; wd_b_s = wdat_b; end
        if (done_b) n_done_b++;
    end

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0;

    function automatic logic [NB-1:0] win(int w, int ox, int oy);
        logic [NB-1:0] b = '0;
        for (int r = 0; r < KS; r++)
            for (int c = 0; c < KS; c++)
                b[(r*KS+c)*PW +: PW] = PW'((oy + r) * w + ox + c);
        return b;
    endfunction

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({busy_a, done_a, rd_a, ref_a, we_a} !== 5'b0) begin
            n_err++; $display("FAIL reset_strobes_a: got %b want 00000", {busy_a, done_a, rd_a, ref_a, we_a});
        end
        n_vec++;
        if (addr_a !== '0 || waddr_a !== '0 || wdat_a !== '0) begin
            n_err++; $display("FAIL reset_addr_a: got src %0d dst %0d data %0d want 0", addr_a, waddr_a, wdat_a);
        end
        n_vec++;
        if (bus_a !== '0 || bus_b !== '0) begin
            n_err++; $display("FAIL reset_bus: got nonzero data_bus want 0");
        end
        n_vec++;
        if ({busy_b, done_b, rd_b, ref_b, we_b} !== 5'b0 || addr_b !== '0 || waddr_b !== '0 || wdat_b !== '0) begin
            n_err++; $display("FAIL reset_outputs_b: got %b/%0d/%0d/%0d want all 0",
                              {busy_b, done_b, rd_b, ref_b, we_b}, addr_b, waddr_b, wdat_b);
        end
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_window();
        int b_rd = n_rd_b, b_ref = n_ref_b, b_we = n_we_b, b_done = n_done_b, t = 0;
        logic [NB-1:0] ew;
        ew = win(BIW, 0, 0);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        #1;
        n_vec++;
        if (busy_b !== 1'b1) begin n_err++; $display("FAIL busy_rise: got %b want 1", busy_b); end
        while (n_done_b == b_done && t < 500) begin @(negedge clk); #1; t++; end
        n_vec++;
        if (t >= 500) begin n_err++; $display("FAIL single_timeout: got no done within 500 cycles want done"); end
        n_vec++;
        if (busy_b !== 1'b0 || done_b !== 1'b1) begin
            n_err++; $display("FAIL done_cycle: got busy %b done %b want busy 0 done 1", busy_b, done_b);
        end
        n_vec++;
        if (n_rd_b - b_rd != 81) begin n_err++; $display("FAIL single_reads: got %0d want 81", n_rd_b - b_rd); end
        n_vec++;
        if (n_ref_b - b_ref != 1 || n_we_b - b_we != 1) begin
            n_err++; $display("FAIL single_pulses: got refresh %0d we %0d want 1 1", n_ref_b - b_ref, n_we_b - b_we);
        end
        n_vec++;
        if (bus_b_s[40*PW +: PW] !== PW'(40) || bus_b_s !== ew) begin
            n_err++; $display("FAIL single_window: got slot40 %0d want 40 (full bus match %b)", bus_b_s[40*PW +: PW], bus_b_s === ew);
        end
        n_vec++;
        if (wa_b_s !== '0 || wd_b_s !== '0) begin
            n_err++; $display("FAIL single_write: got addr %0d data %0d want 0 0", wa_b_s, wd_b_s);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (done_b !== 1'b0) begin n_err++; $display("FAIL done_width: got %b want 0", done_b); end
    endtask

    task automatic test_full_pass();
        int rb = rd_q_a.size(), bb = bus_q_a.size(), wb = wr_q_a.size(), db = n_done_a, got = 0, t = 0;
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++)
                exp_q.push_back('{AW'(oy * 2 + ox), PW'(oy * AIW + ox)});
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        while (n_done_a == db && t < 2000) begin
            @(negedge clk); #1; t++;
            while (wr_q_a.size() > wb + got) begin
                wr_t w; exp_t e;
                w = wr_q_a[wb + got]; got++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL pass_extra_write: got addr %0d want no write", w.addr);
                end else begin
                    e = exp_q.pop_front();
                    if (w.addr !== e.addr || w.data !== e.data) begin
                        n_err++; $display("FAIL pass_write: got addr %0d data %0d want addr %0d data %0d", w.addr, w.data, e.addr, e.data);
                    end
                    n_vec++;
                    if (w.gap != ALAT + 1) begin
                        n_err++; $display("FAIL pass_gap: got %0d cycles want %0d", w.gap, ALAT + 1);
                    end
                end
            end
        end
        n_vec++;
        if (t >= 2000) begin n_err++; $display("FAIL pass_timeout: got no done within 2000 cycles want done"); end
        n_vec++;
        if (got != 4 || exp_q.size() != 0) begin
            n_err++; $display("FAIL pass_writes: got %0d writes, %0d unmatched want 4, 0", got, exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if (rd_q_a.size() - rb != 180) begin n_err++; $display("FAIL pass_reads: got %0d want 180", rd_q_a.size() - rb); end
        n_vec++;
        if (bus_q_a.size() - bb != 4) begin
            n_err++; $display("FAIL pass_refresh: got %0d want 4", bus_q_a.size() - bb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (bus_q_a[bb + i] !== win(AIW, i % 2, i / 2)) begin
                    n_err++; $display("FAIL pass_window%0d: got slot(0,0) %0d slot(0,8) %0d want %0d %0d", i,
                                      bus_q_a[bb + i][0 +: PW], bus_q_a[bb + i][8*PW +: PW], (i / 2) * AIW + i % 2, (i / 2) * AIW + i % 2 + 8);
                end
            end
        end
        n_vec++;
        if (rd_q_a.size() - rb < 91 || rd_q_a[rb] !== AW'(0) || rd_q_a[rb + 81] !== AW'(9) || rd_q_a[rb + 90] !== AW'(10)) begin
            n_err++; $display("FAIL pass_read_addr: got %0d reads (first/shift/refill checked) want addrs 0, 9, 10", rd_q_a.size() - rb);
        end
    endtask

    task automatic test_start_hold();
        int wb = wr_q_a.size(), db = n_done_a, got = 0, t = 0;
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++)
                exp_q.push_back('{AW'(oy * 2 + ox), PW'(oy * AIW + ox)});
        @(negedge clk);
        start_a = 1'b1;
        #1;
        while (done_a !== 1'b1 && t < 2000) begin
            @(negedge clk); #1; t++;
            while (wr_q_a.size() > wb + got) begin
                wr_t w; exp_t e;
                w = wr_q_a[wb + got]; got++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL hold_extra_write: got addr %0d want no write", w.addr);
                end else begin
                    e = exp_q.pop_front();
                    if (w.addr !== e.addr || w.data !== e.data) begin
                        n_err++; $display("FAIL hold_write: got addr %0d data %0d want addr %0d data %0d", w.addr, w.data, e.addr, e.data);
                    end
                end
            end
        end
        start_a = 1'b0;
        n_vec++;
        if (t >= 2000) begin n_err++; $display("FAIL hold_timeout: got no done within 2000 cycles want done"); end
        repeat (20) @(negedge clk);
        #1;
        n_vec++;
        if (n_done_a - db != 1 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL hold_passes: got %0d done, busy %b want 1 done, busy 0", n_done_a - db, busy_a);
        end
        n_vec++;
        if (wr_q_a.size() - wb != 4 || exp_q.size() != 0) begin
            n_err++; $display("FAIL hold_writes: got %0d writes want 4", wr_q_a.size() - wb);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_abort();
        int bb = bus_q_a.size(), wb = wr_q_a.size(), db = n_done_a, t = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        #1;
        while (bus_q_a.size() < bb + 2 && t < 2000) begin @(negedge clk); #1; t++; end
        n_vec++;
        if (t >= 2000) begin n_err++; $display("FAIL abort_timeout: got no second refresh want one"); end
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        n_vec++;
        if ({busy_a, done_a, rd_a, ref_a, we_a} !== 5'b0 || addr_a !== '0 || waddr_a !== '0 || wdat_a !== '0 || bus_a !== '0) begin
            n_err++; $display("FAIL abort_outputs: got strobes %b src %0d dst %0d want all 0",
                              {busy_a, done_a, rd_a, ref_a, we_a}, addr_a, waddr_a);
        end
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_vec++;
        if (wr_q_a.size() - wb != 1 || n_done_a != db || busy_a !== 1'b0) begin
            n_err++; $display("FAIL abort_quiet: got %0d writes %0d done busy %b want 1 0 0", wr_q_a.size() - wb, n_done_a - db, busy_a);
        end else begin
            n_vec++;
            if (wr_q_a[wb].addr !== '0 || wr_q_a[wb].data !== '0) begin
                n_err++; $display("FAIL abort_first_write: got addr %0d data %0d want 0 0", wr_q_a[wb].addr, wr_q_a[wb].data);
            end
        end
        test_full_pass();
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_full_pass();
        test_start_hold();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/filter_scheduler.md
Name: filter_scheduler

Overview:
- Sequences the 9x9 `operation` filter datapath across a full image held in a source pixel RAM.
- Assembles each 81-pixel window into the 810-bit data_bus, pulses refresh, waits the datapath latency, then writes the filter result to a destination RAM.
- Slides horizontally by loading only the new 9-pixel column; reloads the full window at each new output row.
- Sits between the frame memories and the `operation` instance; one filter pass per start.

Parameters:
- IMG_W, 64, source image width in pixels (>= KS).
- IMG_H, 48, source image height in pixels (>= KS).
- KS, 9, window edge; data_bus width = KS*KS*PIX_W.
- PIX_W, 10, pixel width in bits.
- OP_LAT, 2, cycles from refresh pulse to valid op_out (>= 1).
- ADDR_W, 12, address width of source and destination RAMs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to begin a pass; ignored while busy.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last result has been written.
- src_rd  out  1  source RAM read strobe.
- src_addr  out  ADDR_W  source read address = y*IMG_W + x.
- src_data  in  PIX_W  source pixel; valid the cycle after src_rd (1-cycle latency).
- data_bus  out  KS*KS*PIX_W  window to the datapath; pixel (r,c) at bits [(r*KS+c)*PIX_W +: PIX_W], r=0 top row, c=0 left column.
- refresh  out  1  one-cycle pulse telling the datapath that data_bus holds a new window.
- op_out  in  PIX_W  datapath result.
- dst_we  out  1  destination write strobe.
- dst_addr  out  ADDR_W  destination address = oy*OW + ox.
- dst_data  out  PIX_W  result written (op_out sampled in WRITE).

Behaviour:
- Output grid: OW = IMG_W-KS+1, OH = IMG_H-KS+1. Output (ox,oy) uses source pixels x in [ox, ox+KS-1] and y in [oy, oy+KS-1].
- Reset values: every output is 0, state IDLE, ox = oy = 0.
- Reset mid-pass aborts immediately: no done pulse, no further writes. Partial destination contents are undefined.
- IDLE:
  - start=1 moves to FILL with ox = oy = 0; busy rises the next cycle.
- FILL:
  - Issue KS*KS reads in row-major order (r outer, c inner).
  - Capture each src_data one cycle after its read into window slot (r,c).
  - Lasts KS*KS+1 cycles, then go to REFRESH.
- SHIFT:
  - On entry (single cycle), every column c < KS-1 takes column c+1.
  - Then issue KS reads of source column ox+KS-1, rows r = 0..KS-1, into column KS-1.
  - Lasts KS+1 cycles, then go to REFRESH.
- REFRESH: refresh=1 for exactly one cycle; data_bus is stable from this cycle until the next load begins.
- WAIT: OP_LAT cycles; no strobes.
- WRITE:
  - One cycle: dst_we=1, dst_data=op_out, dst_addr=oy*OW+ox.
  - If ox < OW-1: ox+1, go to SHIFT.
  - Else if oy < OH-1: ox=0, oy+1, go to FILL.
  - Else go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- src_rd is high only while a read is issued; dst_we is high only in WRITE.
- Addresses are computed with unsigned arithmetic at ADDR_W width. IMG_W*IMG_H must be <= 2^ADDR_W; this is checked by a static assertion.
- Totals per pass:
  - src_rd pulses = OH*(KS*KS + (OW-1)*KS).
  - dst_we pulses = OW*OH.
  - refresh pulses = OW*OH.

Decomposition:
- Shared package filter_pkg holds:
  - the state enum (IDLE, FILL, SHIFT, REFRESH, WAIT, WRITE, DONE);
  - KS and PIX_W defaults;
  - a window-slot index function (r*KS+c).
- One natural sub-module, window_reg: the KS x KS pixel array with load-slot and shift-left-column operations, outputting the flattened data_bus.
- The FSM, counters and address generation stay in filter_scheduler.

Test Plan:
- Single window: IMG_W=IMG_H=9, OP_LAT=2, src pixel(x,y)=y*9+x, op model returns data_bus[9:0]. Pulse start -> 81 src_rd, 1 refresh with data_bus slot 40 = 40, 1 dst_we at addr 0 with data 0, then done.
- Horizontal slide: IMG_W=10, IMG_H=9 -> 90 src_rd, second refresh with slot (0,0)=1 and slot (0,8)=9, writes addr 0 = 0 and addr 1 = 1.
- Row wrap: IMG_W=10, IMG_H=10, op model returns top-left pixel -> writes addr 0..3 = 0, 1, 10, 11. A second FILL starts at src_addr 10.
- Latency: OP_LAT=4, op model drives op_out only 4 cycles after refresh -> every dst_data is correct, and each refresh-to-dst_we gap is exactly 5 cycles.
- Start handling: start held high during a pass and in the DONE cycle -> exactly one pass runs, with one done pulse.
- Reset abort: rst=0 during WAIT of the 2nd output -> all outputs 0 on the next edge and no further writes; a fresh start reruns the pass correctly.
